// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, ID-stage
// branch/jump flushes and a freeze while the multi-cycle data memory is busy.
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rtaddr_i,
    input  logic [4:0]       ifid_rsaddr_i,
    input  logic [4:0]       ifid_rtaddr_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_stall_o,
    output logic             idex_bubble_o,
    output logic             exmem_stall_o,
    output logic             mem_start_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [WC_W-1:0]   w_wait_cnt_next;
    logic              r_err;
    logic              w_err_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_freeze;
    logic              w_hazard;
    logic              w_pc_write;
    logic              w_ifid_write;
    logic              w_ifid_flush;
    logic              w_idex_stall;
    logic              w_idex_bubble;
    logic              w_exmem_stall;

    // Memory handshake: mem_start_o pulses for the single RUN cycle that sees
    // mem_req_i; the FSM then waits in WAIT for a one-cycle mem_ack_i (or the
    // timeout) and spends one DONE cycle while the instruction leaves EX/MEM.
    assign w_freeze = ((r_state == RUN) && mem_req_i) || (r_state == WAIT);
    assign w_hazard = idex_memread_i && (idex_rtaddr_i != 5'd0) &&
                      ((idex_rtaddr_i == ifid_rsaddr_i) || (idex_rtaddr_i == ifid_rtaddr_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_err_next      = r_err;
        case (r_state)
            RUN: begin
                if (mem_req_i) begin
                    w_next_state    = WAIT;
                    w_wait_cnt_next = '0;
                end
            end
            WAIT: begin
                // Ack beats a coincident timeout, so no error in that case.
                if (mem_ack_i) begin
                    w_next_state = DONE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_err_next   = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + WC_W'(1);
                end
            end
            DONE:    w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_stall = 1'b0;
        if (!rst_i) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_freeze) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
        end else if (w_hazard) begin
            // Branch/jump operands are not ready yet; ID retries next cycle.
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (branch_taken_i || jump_i) begin
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign pc_write_o    = w_pc_write;
    assign ifid_write_o  = w_ifid_write;
    assign ifid_flush_o  = w_ifid_flush;
    assign idex_stall_o  = w_idex_stall;
    assign idex_bubble_o = w_idex_bubble;
    assign exmem_stall_o = w_exmem_stall;
    assign mem_start_o   = rst_i && (r_state == RUN) && mem_req_i;
    assign state_o       = r_state;
    assign stall_cnt_o   = r_stall_cnt;
    assign err_o         = r_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand-written
// memory/reset sequences and randomized cycles against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int W       = 7 + 2 + 1 + CNT_W;

  localparam int P_RUN  = 0;
  localparam int P_WAIT = 1;
  localparam int P_DONE = 2;

  logic             clk;
  logic             rst_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rtaddr_i;
  logic [4:0]       ifid_rsaddr_i;
  logic [4:0]       ifid_rtaddr_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_stall_o;
  logic             idex_bubble_o;
  logic             exmem_stall_o;
  logic             mem_start_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             err_o;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rtaddr_i  (idex_rtaddr_i),
    .ifid_rsaddr_i  (ifid_rsaddr_i),
    .ifid_rtaddr_i  (ifid_rtaddr_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_stall_o   (idex_stall_o),
    .idex_bubble_o  (idex_bubble_o),
    .exmem_stall_o  (exmem_stall_o),
    .mem_start_o    (mem_start_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o),
    .err_o          (err_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Control vector bit order: pc_write, ifid_write, ifid_flush, idex_stall,
  // idex_bubble, exmem_stall, mem_start.
  int m_phase;
  int m_waited;
  int m_cnt;
  bit m_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  logic [6:0]       a_ctrl;
  logic [1:0]       a_state;
  logic             a_err;
  logic [CNT_W-1:0] a_cnt;

  function automatic logic [6:0] model_ctrl();
    bit freeze;
    bit hazard;
    if (!rst_i) return 7'b0010100;
    freeze = (m_phase == P_RUN && mem_req_i) || m_phase == P_WAIT;
    hazard = idex_memread_i && idex_rtaddr_i != 0 &&
             (idex_rtaddr_i == ifid_rsaddr_i || idex_rtaddr_i == ifid_rtaddr_i);
    if (freeze) return {6'b000101, 1'(m_phase == P_RUN)};
    if (hazard) return 7'b0000100;
    if (branch_taken_i || jump_i) return 7'b1110000;
    return 7'b1100000;
  endfunction

  function automatic logic [1:0] model_state_code();
    if (m_phase == P_WAIT) return 2'b01;
    if (m_phase == P_DONE) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_phase  = P_RUN;
    m_waited = 0;
    m_cnt    = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_clock(input logic [6:0] ctrl);
    if (!rst_i) return;
    if (!ctrl[6] && m_cnt < CMAX) m_cnt++;
    if (m_phase == P_RUN) begin
      if (mem_req_i) begin
        m_phase  = P_WAIT;
        m_waited = 0;
      end
    end else if (m_phase == P_WAIT) begin
      if (mem_ack_i) m_phase = P_DONE;
      else if (m_waited == TIMEOUT - 1) begin
        m_err   = 1'b1;
        m_phase = P_DONE;
      end else m_waited++;
    end else begin
      m_phase = P_RUN;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    a_ctrl  = {pc_write_o, ifid_write_o, ifid_flush_o, idex_stall_o,
               idex_bubble_o, exmem_stall_o, mem_start_o};
    a_state = state_o;
    a_err   = err_o;
    a_cnt   = stall_cnt_o;
  endtask

  task automatic compare_model(input string tag);
    logic [W-1:0] exp;
    exp_q.push_back({model_ctrl(), model_state_code(), m_err, CNT_W'(m_cnt)});
    exp = exp_q.pop_front();
    check({tag, ".ctrl"},  32'(a_ctrl),  32'(exp[W-1 -: 7]));
    check({tag, ".state"}, 32'(a_state), 32'(exp[CNT_W+2 -: 2]));
    check({tag, ".err"},   32'(a_err),   32'(exp[CNT_W]));
    check({tag, ".cnt"},   32'(a_cnt),   32'(exp[CNT_W-1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic mr, input logic [4:0] rt,
                      input logic [4:0] rs_if, input logic [4:0] rt_if,
                      input logic br, input logic jp, input logic req, input logic ack);
    logic [6:0] ctrl;
    @(negedge clk);
    idex_memread_i = mr;
    idex_rtaddr_i  = rt;
    ifid_rsaddr_i  = rs_if;
    ifid_rtaddr_i  = rt_if;
    branch_taken_i = br;
    jump_i         = jp;
    mem_req_i      = req;
    mem_ack_i      = ack;
    #1;
    sample();
    compare_model(tag);
    ctrl = model_ctrl();
    @(posedge clk);
    model_clock(ctrl);
  endtask

  task automatic mem_step(input string tag, input logic req, input logic ack);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, req, ack);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    idex_memread_i = 1'b0; idex_rtaddr_i = '0; ifid_rsaddr_i = '0; ifid_rtaddr_i = '0;
    branch_taken_i = 1'b0; jump_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    model_reset();
    sample();
    check("reset.ctrl",  32'(a_ctrl),  32'(7'b0010100));
    check("reset.state", 32'(a_state), 32'd0);
    check("reset.cnt",   32'(a_cnt),   32'd0);
    check("reset.err",   32'(a_err),   32'd0);
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mr;
    logic [4:0] rt;
    logic [4:0] rs_if;
    logic [4:0] rt_if;
    logic       br;
    logic       jp;
    logic [6:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 7'b0000100};
    vecs[1] = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 7'b1100000};
    vecs[2] = '{1'b1, 5'd5,  5'd0, 5'd5,  1'b0, 1'b0, 7'b0000100};
    vecs[3] = '{1'b0, 5'd5,  5'd5, 5'd5,  1'b0, 1'b0, 7'b1100000};
    vecs[4] = '{1'b1, 5'd7,  5'd3, 5'd4,  1'b0, 1'b0, 7'b1100000};
    vecs[5] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 7'b1110000};
    vecs[6] = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 7'b1110000};
    vecs[7] = '{1'b1, 5'd9,  5'd9, 5'd0,  1'b1, 1'b0, 7'b0000100};
    vecs[8] = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 7'b1110000};
    vecs[9] = '{1'b1, 5'd31, 5'd2, 5'd31, 1'b1, 1'b1, 7'b0000100};

    rst_i = 1'b0;
    do_reset();

    // Table: combinational priority with the memory idle.
    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), vecs[i].mr, vecs[i].rt, vecs[i].rs_if, vecs[i].rt_if,
           vecs[i].br, vecs[i].jp, 1'b0, 1'b0);
      check($sformatf("vec%0d.const", i), 32'(a_ctrl), 32'(vecs[i].exp_ctrl));
    end

    // Load-use for one cycle then branch once the hazard has cleared.
    do_reset();
    step("lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu.noflush", 32'(a_ctrl), 32'(7'b0000100));
    step("br", 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("br.flush", 32'(a_ctrl), 32'(7'b1110000));
    check("br.cnt", 32'(a_cnt), 32'd1);

    // Memory handshake, ack three cycles after the start pulse.
    do_reset();
    begin
      logic       reqs[6]   = '{1, 1, 1, 1, 1, 0};
      logic       acks[6]   = '{0, 0, 0, 1, 0, 0};
      logic [1:0] states[6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
      logic       starts[6] = '{1, 0, 0, 0, 0, 0};
      logic       frz[6]    = '{1, 1, 1, 1, 0, 0};
      for (int i = 0; i < 6; i++) begin
        mem_step($sformatf("hs%0d", i), reqs[i], acks[i]);
        check($sformatf("hs%0d.state", i), 32'(a_state), 32'(states[i]));
        check($sformatf("hs%0d.start", i), 32'(a_ctrl[0]), 32'(starts[i]));
        check($sformatf("hs%0d.freeze", i), 32'(a_ctrl[3]), 32'(frz[i]));
      end
      check("hs.cnt", 32'(a_cnt), 32'd4);
    end

    // Ack arriving on the timeout cycle wins: no error.
    do_reset();
    mem_step("at0", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) mem_step("atw", 1'b1, 1'b0);
    mem_step("at4", 1'b1, 1'b1);
    mem_step("at5", 1'b1, 1'b0);
    check("at.state", 32'(a_state), 32'd2);
    check("at.noerr", 32'(a_err), 32'd0);

    // Timeout with no ack: error after TIMEOUT WAIT cycles, then sticky.
    do_reset();
    mem_step("to0", 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) mem_step("tow", 1'b1, 1'b0);
    mem_step("to_done", 1'b0, 1'b0);
    check("to.done_state", 32'(a_state), 32'd2);
    check("to.err", 32'(a_err), 32'd1);
    mem_step("to_run", 1'b0, 1'b0);
    check("to.run_state", 32'(a_state), 32'd0);
    for (int i = 0; i < 3; i++) mem_step("to_after", 1'b0, 1'b1);
    check("to.sticky", 32'(a_err), 32'd1);

    // Asynchronous reset in the middle of WAIT.
    do_reset();
    mem_step("ar0", 1'b1, 1'b0);
    mem_step("ar1", 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_i = 1'b0;
    mem_req_i = 1'b0;
    #1;
    model_reset();
    sample();
    check("ar.state", 32'(a_state), 32'd0);
    check("ar.cnt",   32'(a_cnt),   32'd0);
    check("ar.ctrl",  32'(a_ctrl),  32'(7'b0010100));
    @(posedge clk);
    #2 rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_step("ar_idle", 1'b0, 1'b0);
      check("ar.nostart", 32'(a_ctrl[0]), 32'd0);
    end
    mem_step("ar_new", 1'b1, 1'b0);
    check("ar.newstart", 32'(a_ctrl[0]), 32'd1);

    // Saturation of the stall counter under a persistent load-use hazard.
    do_reset();
    for (int i = 0; i < CMAX + 5; i++) step("sat", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_step("sat_end", 1'b0, 1'b0);
    check("sat.cnt", 32'(a_cnt), 32'(CMAX));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
